avl_counter_bank: RTL and testbench

Parametrised, Avalon-MM-mapped bank of multi-byte hardware event counters (judgment tallies, combo, score) with byte-wide CPU access. Hardware increments the counters directly from game logic instead of relying on NIOS read-modify-write. Atomic multi-byte snapshot-read, atomic staged write, saturate/wrap mode and sticky overflow interrupt are provided. Sits beside the game register file on the same Avalon slave bus.

---
 rtl/avl_counter_bank_pkg.sv | 17 +
 rtl/avl_counter_bank_if.sv | 21 ++
 rtl/avl_counter_bank_cell.sv | 44 ++++
 rtl/avl_counter_bank.sv | 172 +++++++++++++++++
 tb/tb_avl_counter_bank.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/avl_counter_bank_pkg.sv
// Shared constants for the Avalon counter bank: CTRL bit positions,
// register offsets above the counter window, and the per-counter address stride.
package ctr_pkg;

  localparam int CTRL_FREEZE  = 0;
  localparam int CTRL_CLR_ALL = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int CTRL_OFS   = 0;
  localparam int STATUS_OFS = 1;

  // Counters sit on power-of-two strides so index/byte split is a plain shift/mask.
  function automatic int stride(input int cnt_bytes);
    return 1 << $clog2(cnt_bytes);
  endfunction

endpackage

// File: rtl/avl_counter_bank_if.sv
// Byte-wide Avalon-MM slave bus shared with the game register file.
interface avl_counter_bank_if #(
  parameter int ADDR_W = 6
);
  logic              avl_cs;
  logic              avl_rden;
  logic              avl_wren;
  logic [ADDR_W-1:0] avl_addr;
  logic [7:0]        avl_wdata;
  logic [7:0]        avl_rdata;

  modport master (
    output avl_cs, avl_rden, avl_wren, avl_addr, avl_wdata,
    input  avl_rdata
  );

  modport slave (
    input  avl_cs, avl_rden, avl_wren, avl_addr, avl_wdata,
    output avl_rdata
  );
endinterface

// File: rtl/avl_counter_bank_cell.sv
// One hardware event counter: clear > commit > increment, with saturate or
// wrap at all-ones and a one-cycle overflow pulse for the sticky flag.
module ctr_cell #(
  parameter int CW       = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          commit_i,
  input  logic [CW-1:0] commit_val_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Higher-priority events swallow an increment completely, including its overflow.
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (commit_i) begin
      cnt_d = commit_val_i;
    end else if (inc_i) begin
      if (&cnt_q) begin
        ovf_o = 1'b1;
        cnt_d = SATURATE ? cnt_q : '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/avl_counter_bank.sv
// Avalon-mapped bank of NUM_CNT hardware event counters with snapshot reads,
// staged multi-byte writes, sticky overflow flags and a level interrupt.
module avl_counter_bank
  import ctr_pkg::*;
#(
  parameter int NUM_CNT   = 4,
  parameter int CNT_BYTES = 2,
  parameter bit SATURATE  = 1'b1,
  parameter int ADDR_W    = 6
) (
  input  logic                clk,
  input  logic                reset,
  avl_counter_bank_if.slave   avl,
  input  logic [NUM_CNT-1:0]  inc,
  input  logic                hw_clr,
  output logic                irq
);

  localparam int CW     = 8 * CNT_BYTES;
  localparam int STRIDE = stride(CNT_BYTES);
  localparam int SB     = $clog2(STRIDE);
  localparam int CB     = NUM_CNT * STRIDE;
  localparam int IW     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  logic              rd_en, wr_en;
  logic [ADDR_W-1:0] byte_off, cnt_idx;
  logic              cnt_hit, ctrl_hit, stat_hit, top_byte;
  logic              clr_all, clear;

  assign rd_en    = avl.avl_cs & avl.avl_rden;
  assign wr_en    = avl.avl_cs & avl.avl_wren;
  assign byte_off = avl.avl_addr & ADDR_W'(STRIDE - 1);
  assign cnt_idx  = avl.avl_addr >> SB;
  assign cnt_hit  = (cnt_idx < ADDR_W'(NUM_CNT)) && (byte_off < ADDR_W'(CNT_BYTES));
  assign ctrl_hit = (avl.avl_addr == ADDR_W'(CB + CTRL_OFS));
  assign stat_hit = (avl.avl_addr == ADDR_W'(CB + STATUS_OFS));
  assign top_byte = (byte_off == ADDR_W'(CNT_BYTES - 1));
  assign clr_all  = wr_en & ctrl_hit & avl.avl_wdata[CTRL_CLR_ALL];
  assign clear    = hw_clr | clr_all;

  logic [CW-1:0] commit_val;

  generate
    if (CNT_BYTES > 1) begin : g_stage
      logic [CW-9:0] stage_q, stage_d;

      always_comb begin
        stage_d = stage_q;
        if (clear) begin
          stage_d = '0;
        end else if (wr_en && cnt_hit && !top_byte) begin
          for (int k = 0; k < CNT_BYTES - 1; k++) begin
            if (byte_off == ADDR_W'(k)) stage_d[8*k +: 8] = avl.avl_wdata;
          end
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) stage_q <= '0;
        else        stage_q <= stage_d;
      end

      assign commit_val = {avl.avl_wdata, stage_q};
    end else begin : g_direct
      assign commit_val = avl.avl_wdata;
    end
  endgenerate

  logic               freeze_q, freeze_d;
  logic               irq_en_q, irq_en_d;
  logic [CW-1:0]      cnt [NUM_CNT];
  logic [NUM_CNT-1:0] ovf;

  generate
    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cell
      ctr_cell #(
        .CW       (CW),
        .SATURATE (SATURATE)
      ) u_cell (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (clear),
        .commit_i     (wr_en && cnt_hit && top_byte && (cnt_idx == ADDR_W'(gi))),
        .commit_val_i (commit_val),
        .inc_i        (inc[gi] & ~freeze_q),
        .cnt_o        (cnt[gi]),
        .ovf_o        (ovf[gi])
      );
    end
  endgenerate

  logic [NUM_CNT-1:0] flags_q, flags_d;
  logic [CW-1:0]      snap_q, snap_d;
  logic [IW-1:0]      snap_idx_q, snap_idx_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               irq_q, irq_d;
  logic [CW-1:0]      cnt_sel, rd_src, rd_shift;

  always_comb begin
    freeze_d = freeze_q;
    irq_en_d = irq_en_q;
    if (wr_en && ctrl_hit) begin
      freeze_d = avl.avl_wdata[CTRL_FREEZE];
      irq_en_d = avl.avl_wdata[CTRL_IRQ_EN];
    end

    // A new overflow beats a concurrent write-1-to-clear of the same flag.
    flags_d = flags_q;
    if (clear) begin
      flags_d = '0;
    end else begin
      if (wr_en && stat_hit) flags_d = flags_q & ~avl.avl_wdata[NUM_CNT-1:0];
      flags_d = flags_d | ovf;
    end

    cnt_sel = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (cnt_idx == ADDR_W'(k)) cnt_sel = cnt[k];
    end

    snap_d     = snap_q;
    snap_idx_d = snap_idx_q;
    if (rd_en && cnt_hit && (byte_off == '0)) begin
      snap_d     = cnt_sel;
      snap_idx_d = cnt_idx[IW-1:0];
    end
    if (clear) snap_d = '0;

    // Upper bytes come from the snapshot only if it was taken from this counter.
    rd_src   = ((byte_off != '0) && (ADDR_W'(snap_idx_q) == cnt_idx)) ? snap_q : cnt_sel;
    rd_shift = rd_src >> {byte_off, 3'b000};

    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = 8'h00;
      if (cnt_hit) begin
        rdata_d = rd_shift[7:0];
      end else if (ctrl_hit) begin
        rdata_d[CTRL_FREEZE] = freeze_q;
        rdata_d[CTRL_IRQ_EN] = irq_en_q;
      end else if (stat_hit) begin
        rdata_d[NUM_CNT-1:0] = flags_q;
      end
    end

    irq_d = irq_en_q & (|flags_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freeze_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      flags_q    <= '0;
      snap_q     <= '0;
      snap_idx_q <= '0;
      rdata_q    <= 8'h00;
      irq_q      <= 1'b0;
    end else begin
      freeze_q   <= freeze_d;
      irq_en_q   <= irq_en_d;
      flags_q    <= flags_d;
      snap_q     <= snap_d;
      snap_idx_q <= snap_idx_d;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
    end
  end

  assign avl.avl_rdata = rdata_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_avl_counter_bank.sv
// Drives a saturating and a wrapping counter bank with identical traffic and
// compares both against an arithmetic model of the register map.
module tb_avl_counter_bank;

  localparam int NUM_CNT   = 4;
  localparam int CNT_BYTES = 2;
  localparam int ADDR_W    = 6;
  localparam int CB        = 8;
  localparam int MAXV      = 65535;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              cs = 1'b0, rden = 1'b0, wren = 1'b0, hw_clr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [7:0]        wdata = 8'h00;
  logic [NUM_CNT-1:0] inc = '0;
  logic              irq_s, irq_w;

  avl_counter_bank_if #(.ADDR_W(ADDR_W)) bus_s ();
  avl_counter_bank_if #(.ADDR_W(ADDR_W)) bus_w ();

  assign bus_s.avl_cs = cs;    assign bus_w.avl_cs = cs;
  assign bus_s.avl_rden = rden; assign bus_w.avl_rden = rden;
  assign bus_s.avl_wren = wren; assign bus_w.avl_wren = wren;
  assign bus_s.avl_addr = addr; assign bus_w.avl_addr = addr;
  assign bus_s.avl_wdata = wdata; assign bus_w.avl_wdata = wdata;

  avl_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_BYTES(CNT_BYTES), .SATURATE(1'b1), .ADDR_W(ADDR_W)) dut_s (
    .clk(clk), .reset(reset), .avl(bus_s), .inc(inc), .hw_clr(hw_clr), .irq(irq_s));

  avl_counter_bank #(.NUM_CNT(NUM_CNT), .CNT_BYTES(CNT_BYTES), .SATURATE(1'b0), .ADDR_W(ADDR_W)) dut_w (
    .clk(clk), .reset(reset), .avl(bus_w), .inc(inc), .hw_clr(hw_clr), .irq(irq_w));

  // Model index 0 = saturating bank, 1 = wrapping bank.
  int m_cnt [2][NUM_CNT];
  int m_flags [2];
  int m_snap [2];
  int m_rdata [2];
  int m_irq [2];
  int m_stage, m_snap_idx;
  bit m_freeze, m_irq_en;

  logic [7:0] got_rd [2];
  logic       got_irq [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < NUM_CNT; k++) m_cnt[m][k] = 0;
      m_flags[m] = 0; m_snap[m] = 0; m_rdata[m] = 0; m_irq[m] = 0;
    end
    m_stage = 0; m_snap_idx = 0; m_freeze = 0; m_irq_en = 0;
  endtask

  task automatic step(input bit rd, input bit wr, input int a, input int wd,
                      input int incv, input bit clr);
    int  e, ovf;
    bit  clear;
    cs = rd | wr; rden = rd; wren = wr;
    addr = ADDR_W'(a); wdata = 8'(wd); inc = NUM_CNT'(incv); hw_clr = clr;
    clear = clr || (wr && a == CB && wd[1]);
    for (int m = 0; m < 2; m++) begin
      e = 0;
      if (a < CB) begin
        if (a % 2 == 0) e = m_cnt[m][a/2] & 255;
        else e = (((m_snap_idx == a/2) ? m_snap[m] : m_cnt[m][a/2]) >> 8) & 255;
      end else if (a == CB) begin
        e = (int'(m_irq_en) << 2) | int'(m_freeze);
      end else if (a == CB + 1) begin
        e = m_flags[m];
      end
      if (rd) m_rdata[m] = e;
      m_irq[m] = (m_irq_en && m_flags[m] != 0) ? 1 : 0;
      if (rd && a < CB && a % 2 == 0) m_snap[m] = m_cnt[m][a/2];
      if (clear) m_snap[m] = 0;
      ovf = 0;
      for (int k = 0; k < NUM_CNT; k++) begin
        if (clear) m_cnt[m][k] = 0;
        else if (wr && a < CB && a % 2 == 1 && a/2 == k) m_cnt[m][k] = (wd & 255) * 256 + m_stage;
        else if (incv[k] && !m_freeze) begin
          if (m_cnt[m][k] == MAXV) begin
            ovf |= (1 << k);
            m_cnt[m][k] = (m == 0) ? MAXV : 0;
          end else begin
            m_cnt[m][k] = m_cnt[m][k] + 1;
          end
        end
      end
      if (clear) m_flags[m] = 0;
      else begin
        if (wr && a == CB + 1) m_flags[m] = m_flags[m] & ~wd & 15;
        m_flags[m] = m_flags[m] | ovf;
      end
    end
    if (rd && a < CB && a % 2 == 0) m_snap_idx = a / 2;
    if (clear) m_stage = 0;
    else if (wr && a < CB && a % 2 == 0) m_stage = wd & 255;
    if (wr && a == CB) begin m_freeze = wd[0]; m_irq_en = wd[2]; end
    @(posedge clk);
    #1;
    got_rd[0] = bus_s.avl_rdata; got_rd[1] = bus_w.avl_rdata;
    got_irq[0] = irq_s; got_irq[1] = irq_w;
    cs = 1'b0; rden = 1'b0; wren = 1'b0; hw_clr = 1'b0; inc = '0;
  endtask

  task automatic wr_b(input int a, input int d); step(1'b0, 1'b1, a, d, 0, 1'b0); endtask
  task automatic rd_b(input int a);              step(1'b1, 1'b0, a, 0, 0, 1'b0); endtask
  task automatic pulse(input int v);             step(1'b0, 1'b0, 0, 0, v, 1'b0); endtask

  task automatic do_reset();
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus_s.avl_rdata !== 8'h00 || bus_w.avl_rdata !== 8'h00 || irq_s !== 1'b0 || irq_w !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: rdata %h/%h irq %b/%b, required 00/00 irq 0/0",
               bus_s.avl_rdata, bus_w.avl_rdata, irq_s, irq_w);
    end
    rd_b(0);
    n_checks++;
    if (got_rd[0] !== 8'h00 || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL reset_cnt0: got %h/%h, required 00", got_rd[0], got_rd[1]);
    end
    rd_b(CB + 1);
    n_checks++;
    if (got_rd[0] !== 8'h00 || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL reset_status: got %h/%h, required 00", got_rd[0], got_rd[1]);
    end
    $display("test_reset done");
  endtask

  task automatic test_write_read();
    wr_b(0, 8'h34); wr_b(1, 8'h12);
    rd_b(0);
    n_checks++;
    if (got_rd[0] !== 8'h34 || got_rd[1] !== 8'h34) begin
      n_fail++; $display("FAIL wr_rd_lo: got %h/%h, required 34", got_rd[0], got_rd[1]);
    end
    rd_b(1);
    n_checks++;
    if (got_rd[0] !== 8'h12 || got_rd[1] !== 8'h12) begin
      n_fail++; $display("FAIL wr_rd_hi: got %h/%h, required 12", got_rd[0], got_rd[1]);
    end
    $display("test_write_read done");
  endtask

  task automatic test_snapshot();
    logic [7:0] expv [4];
    int         seq  [4];
    expv[0] = 8'hFF; expv[1] = 8'h00; expv[2] = 8'h00; expv[3] = 8'h01;
    seq[0] = 0; seq[1] = 1; seq[2] = 0; seq[3] = 1;
    wr_b(0, 8'hFF); wr_b(1, 8'h00);
    for (int s = 0; s < 4; s++) begin
      rd_b(seq[s]);
      if (s == 0) pulse(1);
      n_checks++;
      if (got_rd[0] !== expv[s] || got_rd[1] !== expv[s]) begin
        n_fail++;
        $display("FAIL snapshot_%0d: got %h/%h, required %h", s, got_rd[0], got_rd[1], expv[s]);
      end
    end
    $display("test_snapshot done");
  endtask

  task automatic test_overflow();
    wr_b(2, 8'hFF); wr_b(3, 8'hFF); wr_b(CB, 8'h04);
    pulse(2);
    n_checks++;
    if (got_irq[0] !== 1'b0 || got_irq[1] !== 1'b0) begin
      n_fail++; $display("FAIL irq_early: got %b/%b, required 0", got_irq[0], got_irq[1]);
    end
    pulse(0);
    n_checks++;
    if (got_irq[0] !== 1'b1 || got_irq[1] !== 1'b1) begin
      n_fail++; $display("FAIL irq_t2: got %b/%b, required 1", got_irq[0], got_irq[1]);
    end
    rd_b(2);
    n_checks++;
    if (got_rd[0] !== 8'hFF || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL ovf_lo: got %h/%h, required FF/00", got_rd[0], got_rd[1]);
    end
    rd_b(3);
    n_checks++;
    if (got_rd[0] !== 8'hFF || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL ovf_hi: got %h/%h, required FF/00", got_rd[0], got_rd[1]);
    end
    rd_b(CB + 1);
    n_checks++;
    if (got_rd[0] !== 8'h02 || got_rd[1] !== 8'h02) begin
      n_fail++; $display("FAIL ovf_status: got %h/%h, required 02", got_rd[0], got_rd[1]);
    end
    wr_b(CB + 1, 8'h02);
    rd_b(CB + 1);
    n_checks++;
    if (got_rd[0] !== 8'h00 || got_rd[1] !== 8'h00 || got_irq[0] !== 1'b0 || got_irq[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c: status %h/%h irq %b/%b, required 00 irq 0", got_rd[0], got_rd[1], got_irq[0], got_irq[1]);
    end
    $display("test_overflow done");
  endtask

  task automatic test_w1c_concurrent();
    wr_b(4, 8'hFF); wr_b(5, 8'hFF); pulse(4);
    wr_b(4, 8'hFF); wr_b(5, 8'hFF);
    step(1'b0, 1'b1, CB + 1, 8'h04, 4, 1'b0);
    rd_b(CB + 1);
    n_checks++;
    if (got_rd[0] !== 8'h04 || got_rd[1] !== 8'h04) begin
      n_fail++; $display("FAIL w1c_vs_ovf: got %h/%h, required 04", got_rd[0], got_rd[1]);
    end
    wr_b(CB + 1, 8'h0F);
    $display("test_w1c_concurrent done");
  endtask

  task automatic test_priority();
    wr_b(0, 8'h05);
    step(1'b0, 1'b1, 1, 8'h00, 1, 1'b0);
    rd_b(0);
    n_checks++;
    if (got_rd[0] !== 8'h05 || got_rd[1] !== 8'h05) begin
      n_fail++; $display("FAIL commit_vs_inc: got %h/%h, required 05", got_rd[0], got_rd[1]);
    end
    step(1'b0, 1'b0, 0, 0, 1, 1'b1);
    rd_b(0);
    n_checks++;
    if (got_rd[0] !== 8'h00 || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL hwclr_vs_inc: got %h/%h, required 00", got_rd[0], got_rd[1]);
    end
    wr_b(0, 8'h22); wr_b(1, 8'h00); wr_b(CB, 8'h05);
    for (int k = 0; k < 3; k++) pulse(1);
    rd_b(0);
    n_checks++;
    if (got_rd[0] !== 8'h22 || got_rd[1] !== 8'h22) begin
      n_fail++; $display("FAIL freeze: got %h/%h, required 22", got_rd[0], got_rd[1]);
    end
    wr_b(CB, 8'h06);
    rd_b(CB);
    n_checks++;
    if (got_rd[0] !== 8'h04 || got_rd[1] !== 8'h04) begin
      n_fail++; $display("FAIL ctrl_readback: got %h/%h, required 04", got_rd[0], got_rd[1]);
    end
    rd_b(0);
    n_checks++;
    if (got_rd[0] !== 8'h00 || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL clear_all: got %h/%h, required 00", got_rd[0], got_rd[1]);
    end
    rd_b(CB + 5);
    n_checks++;
    if (got_rd[0] !== 8'h00 || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL unmapped: got %h/%h, required 00", got_rd[0], got_rd[1]);
    end
    $display("test_priority done");
  endtask

  task automatic test_reset_stage();
    wr_b(0, 8'hAB);
    do_reset();
    wr_b(1, 8'h77);
    rd_b(0);
    n_checks++;
    if (got_rd[0] !== 8'h00 || got_rd[1] !== 8'h00) begin
      n_fail++; $display("FAIL reset_stage_lo: got %h/%h, required 00", got_rd[0], got_rd[1]);
    end
    rd_b(1);
    n_checks++;
    if (got_rd[0] !== 8'h77 || got_rd[1] !== 8'h77) begin
      n_fail++; $display("FAIL reset_stage_hi: got %h/%h, required 77", got_rd[0], got_rd[1]);
    end
    $display("test_reset_stage done");
  endtask

  task automatic test_back_to_back();
    int op, a, wd, iv, errs;
    bit cl;
    errs = 0;
    for (int c = 0; c < 600; c++) begin
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 63) : $urandom_range(0, CB + 2);
      wd = ($urandom_range(0, 1) == 1) ? 8'hFF : $urandom_range(0, 255);
      if (a == CB && $urandom_range(0, 7) != 0) wd = wd & 8'hFD;
      iv = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 15) : 0;
      cl = ($urandom_range(0, 63) == 0);
      step(op == 1 || op == 3, op == 2, a, wd, iv, cl);
      for (int m = 0; m < 2; m++) begin
        n_checks++;
        if (got_rd[m] !== 8'(m_rdata[m]) || got_irq[m] !== m_irq[m][0]) begin
          n_fail++; errs++;
          $display("FAIL random_c%0d_dut%0d: rdata %h irq %b, required %h irq %0d",
                   c, m, got_rd[m], got_irq[m], 8'(m_rdata[m]), m_irq[m]);
        end
      end
    end
    $display("test_back_to_back done, %0d mismatching cycles", errs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_snapshot();
    test_overflow();
    test_w1c_concurrent();
    test_priority();
    test_reset_stage();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
